// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter:
//   - OVERSAMPLE_RATE : sample ticks per bit period
//   - SAMPLE_*        : sample counter positions used for majority voting
//   - uart_state_t    : frame state encoding
//   - majority3()     : 2-of-3 vote used to reject short line glitches
//   - tick_divisor()  : sysclk cycles per sample tick
// -----------------------------------------------------------------------------
package uart_pkg;

  // Sample ticks per bit. The receiver's 4-bit sample counter relies on this
  // being 16 so that the counter wraps exactly once per bit period.
  localparam int unsigned OVERSAMPLE_RATE = 16;

  // Positions within a bit period where the line is sampled. They are centred
  // on the middle of the bit, and the decision is taken at the last one.
  localparam logic [3:0] SAMPLE_FIRST = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LAST  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

  // 2-of-3 vote: a single corrupted sample cannot flip the decided bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Integer divide; the result must be at least 2 for the tick generator.
  function automatic int unsigned tick_divisor(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider that produces a one-cycle enable every DIV sysclk
// cycles. The counter can be restarted with clear so the first tick lands
// exactly DIV cycles later, which lets the receiver align its sampling to the
// detected start edge.
//
// Ports
//   sysclk : clock, all logic on rising edge
//   reset  : synchronous active-high reset
//   clear  : synchronous restart of the divider (counter to 0)
//   tick   : one-cycle enable, high while the counter holds DIV-1
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  // DIV is expected to be >= 2; the guard keeps the width legal regardless.
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values of the others, regardless of the
  // order in which always_ff blocks are evaluated.
  always_ff @(posedge sysclk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver with 16x oversampling and 2-of-3 majority voting at the
// middle of every bit. A frame whose stop bit votes low is reported as a
// framing error, after which the receiver waits for the line to go high again
// so a held break cannot retrigger it.
//
// Parameters
//   CLK_HZ     : sysclk frequency in Hz
//   BAUD       : line bit rate
//   OVERSAMPLE : sample ticks per bit (fixed at 16)
//
// Ports
//   sysclk    : clock, all logic on rising edge
//   reset     : synchronous active-high reset
//   UART_RX   : asynchronous serial input, idle high
//   RX_DATA   : last correctly framed byte (LSB received first)
//   RX_STATUS : one-cycle pulse, RX_DATA newly valid
//   RX_ERR    : one-cycle pulse, stop bit sampled low
//   RX_BUSY   : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_RATE
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_ERR,
  output logic       RX_BUSY
);

  localparam int unsigned DIV = tick_divisor(CLK_HZ, BAUD, OVERSAMPLE);

  uart_state_t state;
  uart_state_t next_state;

  logic       rx_meta;
  logic       rx_sync;
  logic       tick;
  logic       clear;
  logic [3:0] sample_cnt;
  logic       sample_first;
  logic       sample_mid;
  logic       decide;
  logic       bit_val;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       load_data;
  logic       frame_err;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Resets to the idle level so reset release never looks
  // like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample timing. Both the divider and the sample counter are held at zero
  // while idle, so the first tick after a start edge arrives DIV cycles later
  // and samples 7/8/9 straddle the middle of every bit.
  // ---------------------------------------------------------------------------
  assign clear = (state == ST_IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (clear),
    .tick   (tick)
  );

  // The 4-bit counter wraps 15 -> 0 naturally: one wrap per bit period.
  always_ff @(posedge sysclk) begin
    if (reset || clear) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= sample_cnt + 4'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sample_first <= 1'b0;
      sample_mid   <= 1'b0;
    end else if (tick) begin
      if (sample_cnt == SAMPLE_FIRST) sample_first <= rx_sync;
      if (sample_cnt == SAMPLE_MID)   sample_mid   <= rx_sync;
    end
  end

  // The third sample is the live synchronized line at the decision tick.
  assign decide  = tick && (sample_cnt == SAMPLE_LAST);
  assign bit_val = majority3(sample_first, sample_mid, rx_sync);

  // ---------------------------------------------------------------------------
  // Frame FSM: state register + next-state logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    load_data  = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_sync) next_state = ST_START;
      end
      ST_START: begin
        // A start bit that votes high was a glitch; drop it silently.
        if (decide) next_state = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide && (bit_idx == 3'd7)) next_state = ST_STOP;
      end
      ST_STOP: begin
        // Leaving at sample 9 (not at the end of the stop bit) leaves half a
        // bit of margin so a start bit directly after the stop is caught.
        if (decide) begin
          if (bit_val) begin
            next_state = ST_IDLE;
            load_data  = 1'b1;
          end else begin
            next_state = ST_WAIT_HIGH;
            frame_err  = 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_sync) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs. The status/error strobes are registered
  // copies of single-cycle FSM decisions, so they are mutually exclusive and
  // last exactly one cycle.
  // ---------------------------------------------------------------------------
  // NOTE: the shift register is reset along with the control state even
  // though its contents are only consumed after a full frame; this keeps
  // RX_DATA and the datapath deterministic from the first cycle after reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      bit_idx   <= '0;
      shift_reg <= '0;
      RX_DATA   <= '0;
      RX_STATUS <= 1'b0;
      RX_ERR    <= 1'b0;
    end else begin
      RX_STATUS <= load_data;
      RX_ERR    <= frame_err;
      if (load_data) RX_DATA <= shift_reg;

      if ((state == ST_START) && decide) begin
        bit_idx <= '0;
      end else if ((state == ST_DATA) && decide) begin
        shift_reg[bit_idx] <= bit_val;
        bit_idx            <= bit_idx + 3'd1;
      end
    end
  end

  assign RX_BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver at CLK_HZ=1_600_000, BAUD=10_000
// (10 sysclk cycles per tick, 160 cycles per bit).
// Timing reference: a start edge driven just after sysclk edge E0 is seen by
// the FSM at edge E0+3, mid-bit samples read the line at offsets 81/91/101
// within each bit, and the stop-bit decision lands on edge E0+1543.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int unsigned CLK_HZ    = 1_600_000;
  localparam int unsigned BAUD      = 10_000;
  localparam int          BIT_CYC   = 160;
  localparam int          STOP_LAT  = 1543;

  logic       sysclk  = 1'b0;
  logic       reset   = 1'b1;
  logic       UART_RX = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       RX_ERR;
  logic       RX_BUSY;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int status_cnt = 0;
  int err_cnt    = 0;
  int both_cnt   = 0;
  int last_status_cyc = -1;
  int last_err_cyc    = -1;
  logic [7:0] data_q[$];

  uart_receiver #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS),
    .RX_ERR    (RX_ERR),
    .RX_BUSY   (RX_BUSY)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle; a strobe stuck high shows up as extra
  // pulses in the counts.
  always @(negedge sysclk) begin
    if (RX_STATUS) begin
      status_cnt++;
      last_status_cyc = cyc;
      data_q.push_back(RX_DATA);
    end
    if (RX_ERR) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (RX_STATUS && RX_ERR) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n edges and settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Drive one 8N1 frame. glitch_bit inverts the line for 15 cycles around the
  // middle of that bit position; rst_bit raises reset 50 cycles into that bit
  // and leaves it high. Bit positions: 0 start, 1..8 data, 9 stop.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int glitch_bit, input int rst_bit,
                            output int fall_cyc);
    logic [9:0] bits;
    bits     = {stop, data, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      UART_RX = bits[i];
      if (i == glitch_bit) begin
        cycles(73);
        UART_RX = ~bits[i];
        cycles(15);
        UART_RX = bits[i];
        cycles(72);
      end else if (i == rst_bit) begin
        cycles(50);
        reset = 1'b1;
        cycles(BIT_CYC - 50);
      end else begin
        cycles(BIT_CYC);
      end
    end
  endtask

  initial begin
    int fall;

    // Reset state
    reset   = 1'b1;
    UART_RX = 1'b1;
    cycles(5);
    check("rst_data",   RX_DATA,   8'h00);
    check("rst_status", RX_STATUS, 1'b0);
    check("rst_err",    RX_ERR,    1'b0);
    check("rst_busy",   RX_BUSY,   1'b0);
    reset = 1'b0;
    cycles(20);

    // Single good frame 0x55, with stop-decision latency
    send_frame(8'h55, 1'b1, -1, -1, fall);
    check("f55_status_cnt", status_cnt, 1);
    check("f55_data",       RX_DATA,    8'h55);
    check("f55_latency",    last_status_cyc - fall, STOP_LAT);
    check("f55_err_cnt",    err_cnt,    0);
    check("f55_busy_idle",  RX_BUSY,    1'b0);
    cycles(50);

    // Back-to-back frames, no idle gap
    send_frame(8'hA3, 1'b1, -1, -1, fall);
    send_frame(8'h0F, 1'b1, -1, -1, fall);
    check("b2b_status_cnt", status_cnt, 3);
    check("b2b_first",      data_q[1],  8'hA3);
    check("b2b_second",     data_q[2],  8'h0F);
    check("b2b_data",       RX_DATA,    8'h0F);
    cycles(50);

    // Framing error: 0xFF, stop low, line held low for 5 bit times in total
    send_frame(8'hFF, 1'b0, -1, -1, fall);
    cycles(4 * BIT_CYC - 40);                    // now fall+2200, line still low
    check("ferr_err_cnt",    err_cnt,              1);
    check("ferr_latency",    last_err_cyc - fall,  STOP_LAT);
    check("ferr_status_cnt", status_cnt,           3);
    check("ferr_data_kept",  RX_DATA,              8'h0F);
    check("ferr_busy_held",  RX_BUSY,              1'b1);
    cycles(40);
    UART_RX = 1'b1;                              // line high at fall+2240
    cycles(10);
    check("ferr_busy_release", RX_BUSY, 1'b0);
    cycles(200);
    check("ferr_no_second", err_cnt, 1);

    // False start: 60-cycle low pulse on an idle line
    fall    = cyc;
    UART_RX = 1'b0;
    cycles(60);
    UART_RX = 1'b1;
    cycles(42);                                  // fall+102, before decision
    check("fs_busy_before", RX_BUSY, 1'b1);
    cycles(1);                                   // fall+103, after decision
    check("fs_busy_after",  RX_BUSY, 1'b0);
    cycles(300);
    check("fs_status_cnt", status_cnt, 3);
    check("fs_err_cnt",    err_cnt,    1);

    // Glitch: 0x81 with a 15-cycle high pulse mid data bit 3 (position 4)
    send_frame(8'h81, 1'b1, 4, -1, fall);
    check("gl_status_cnt", status_cnt, 4);
    check("gl_data",       RX_DATA,    8'h81);
    cycles(50);

    // Reset during data bit 4 (position 5) of 0x3C, held to the end of frame
    send_frame(8'h3C, 1'b1, -1, 5, fall);
    check("mrst_data",       RX_DATA,    8'h00);
    check("mrst_status",     RX_STATUS,  1'b0);
    check("mrst_err",        RX_ERR,     1'b0);
    check("mrst_busy",       RX_BUSY,    1'b0);
    check("mrst_status_cnt", status_cnt, 4);
    check("mrst_err_cnt",    err_cnt,    1);
    cycles(20);
    reset = 1'b0;
    cycles(20);
    send_frame(8'hC3, 1'b1, -1, -1, fall);
    check("post_rst_status_cnt", status_cnt, 5);
    check("post_rst_data",       RX_DATA,    8'hC3);
    check("post_rst_latency",    last_status_cyc - fall, STOP_LAT);
    cycles(50);

    // Global pulse properties
    check("never_both",     both_cnt, 0);
    check("final_err_cnt",  err_cnt,  1);
    check("final_status",   status_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
